// File: rtl/seq_mul_64bit.sv
// ---------------------------------------------------------------------------
// seq_mul_64bit
//   Iterative shift-and-add unsigned multiplier, 64x64 -> 128-bit product,
//   one multiplier bit retired per clock. Built around a single 64-bit ripple
//   adder (adder_64bit). That adder is made of per-bit full-adder cells
//   (fa_cell) instantiated in a generate array.
//
//   Optional feature (compile-time macro MUL_ZERO_BYPASS_EN):
//     When it is defined, a start with a zero operand goes straight to DONE
//     with a zero product, giving a one-cycle latency. When it is undefined,
//     every operation runs all 64 iterations.
//
// Ports (seq_mul_64bit):
//   clk         in   1   rising-edge clock
//   rst         in   1   asynchronous, active-high reset
//   start       in   1   request, sampled only in IDLE
//   op_a        in   64  multiplicand, captured with start
//   op_b        in   64  multiplier, captured with start
//   busy        out  1   high while state != IDLE
//   done        out  1   one-cycle pulse, product valid
//   product_hi  out  64  upper half of op_a*op_b
//   product_lo  out  64  lower half of op_a*op_b
// ---------------------------------------------------------------------------

// One bit slice of the ripple adder.
//   a, b, ci : addend bits and carry in
//   s, co    : sum bit and carry out
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

// Fixed 64-bit ripple-carry adder.
//   a, b : 64-bit addends
//   cin  : carry in
//   sum  : 64-bit sum
//   cout : carry out of bit 63
module adder_64bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout
);
  logic [64:0] c;

  assign c[0] = cin;

  for (genvar g = 0; g < 64; g++) begin : g_bit
    fa_cell u_fa (
      .a  (a[g]),
      .b  (b[g]),
      .ci (c[g]),
      .s  (sum[g]),
      .co (c[g+1])
    );
  end

  assign cout = c[64];
endmodule

// Top: control FSM plus the {hi,lo} partial-product shift register.
module seq_mul_64bit #(
  // The adder is the fixed 64-bit ripple adder, so only 64 is supported.
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [5:0]       count;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             zero_op;

  // Add the multiplicand only when the current multiplier bit (lo[0]) is set.
  assign add_b = lo[0] ? mcand : '0;

  adder_64bit u_add (
    .a    (hi),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

`ifdef MUL_ZERO_BYPASS_EN
  assign zero_op = (op_a == '0) || (op_b == '0);
`else
  assign zero_op = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      count <= '0;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand <= op_a;
            count <= '0;
            hi    <= '0;
            if (zero_op) begin
              lo    <= '0;
              state <= ST_DONE;
            end else begin
              lo    <= op_b;
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          // Shift the 65-bit {cout,sum} right by one into {hi,lo}. The
          // consumed multiplier bit falls off the bottom of lo, and the
          // adder's carry out becomes hi[63], so no carry is lost.
          hi    <= {add_cout, add_sum[WIDTH-1:1]};
          lo    <= {add_sum[0], lo[WIDTH-1:1]};
          count <= count + 6'd1;  // 63 -> 0 wrap coincides with the DONE entry
          if (count == 6'd63)
            state <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);
  assign product_hi = hi;
  assign product_lo = lo;

endmodule

// File: tb/tb_seq_mul_64bit.sv
// ---------------------------------------------------------------------------
// tb_seq_mul_64bit
//   Directed-vector bench for seq_mul_64bit, plus a batch of random operand
//   pairs checked against a 128-bit reference product. Inputs are driven and
//   outputs sampled 1ns after the rising edge.
//   Latency here is counted as the number of rising edges after the start
//   edge E0 until done is seen: 64 for the iterative path and 0 for the
//   zero bypass (where done is already high in the cycle after E0).
// ---------------------------------------------------------------------------
module tb_seq_mul_64bit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic        busy;
  logic        done;
  logic [63:0] product_hi;
  logic [63:0] product_lo;

  int nvec;
  int nerr;

  seq_mul_64bit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .product_hi (product_hi),
    .product_lo (product_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic [63:0] a, input logic [63:0] b);
`ifdef MUL_ZERO_BYPASS_EN
    if (a == 64'd0 || b == 64'd0) return 0;
`endif
    return 64;
  endfunction

  // Launch one multiply and wait for done. Returns the observed latency and
  // the number of sampled cycles with busy high, counting from the E0 sample.
  // On return the bench is in the cycle after DONE, which is an IDLE cycle.
  task automatic run_mul(input logic [63:0] a, input logic [63:0] b,
                         output int lat, output int bcnt);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op_a  = ~a;   // later operand changes must not matter
    op_b  = ~b;
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bcnt++;
    end
    if (lat >= 200) chk("done_timeout", 128'(lat), 128'(exp_lat(a, b)));
    @(posedge clk); #1;
  endtask

  // Run one multiply and check its product, latency and single done pulse.
  task automatic mul_check(input string tag, input logic [63:0] a, input logic [63:0] b,
                           input logic [127:0] exp_p);
    int lat, bcnt;
    logic [127:0] got_p;
    run_mul(a, b, lat, bcnt);
    got_p = {product_hi, product_lo};  // sampled in the IDLE cycle after done
    chk({tag, "_prod"}, got_p, exp_p);
    chk({tag, "_lat"}, 128'(lat), 128'(exp_lat(a, b)));
    chk({tag, "_pulse"}, {126'd0, busy, done}, 128'd0);
  endtask

  initial begin
    int lat, bcnt, dcnt;
    logic [63:0] ra, rb;
    nvec  = 0;
    nerr  = 0;
    rst   = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;

    // reset state
    #3;
    chk("rst_state", {busy, done, product_hi, product_lo}, 130'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // 1: 3*5, latency 64, busy for 65 cycles
    run_mul(64'd3, 64'd5, lat, bcnt);
    chk("t1_prod", {product_hi, product_lo}, 128'd15);
    chk("t1_lat", 128'(lat), 128'd64);
    chk("t1_busy", 128'(bcnt), 128'd65);
    chk("t1_idle", {126'd0, busy, done}, 128'd0);
    // result must hold after DONE
    repeat (5) @(posedge clk);
    #1;
    chk("t1_hold", {product_hi, product_lo}, 128'd15);

    // 2: all ones squared, exercises carry capture
    mul_check("t2", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              {64'hFFFF_FFFF_FFFF_FFFE, 64'h1});

    // 3: MSB times 2, then identity
    mul_check("t3a", 64'h8000_0000_0000_0000, 64'd2, {64'd1, 64'd0});
    mul_check("t3b", 64'hDEAD_BEEF, 64'd1, {64'd0, 64'hDEAD_BEEF});

    // 4: starts while busy are ignored; a back-to-back start is accepted
    op_a = 64'd3; op_b = 64'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dcnt = 0;
    repeat (10) begin @(posedge clk); #1; end
    op_a = 64'd7; op_b = 64'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 11;
    while (!done && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("t4_lat", 128'(lat), 128'd64);
    dcnt += done ? 1 : 0;
    // in the DONE cycle: pulse start again
    op_a = 64'd7; op_b = 64'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dcnt += done ? 1 : 0;
    chk("t4_ignored", {126'd0, busy, done}, 128'd0);
    chk("t4_prod", {product_hi, product_lo}, 128'd15);
    chk("t4_pulses", 128'(dcnt), 128'd1);
    // this cycle is the IDLE right after DONE
    mul_check("t4_b2b", 64'd7, 64'd7, 128'd49);

    // 5: asynchronous reset mid-operation
    op_a = 64'd9; op_b = 64'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst", {busy, done, product_hi, product_lo}, 130'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("t5_idle", {126'd0, busy, done}, 128'd0);
    mul_check("t5_after", 64'd9, 64'd9, 128'd81);

    // 6: zero operand (latency depends on the bypass option)
    mul_check("t6", 64'd0, 64'h1234, 128'd0);
    mul_check("t6b", 64'h55, 64'd0, 128'd0);

    // random pairs against a 128-bit reference
    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 100 == 7) ra = 64'd0;
      if (i % 100 == 13) rb = 64'd0;
      mul_check("rnd", ra, rb, {64'd0, ra} * {64'd0, rb});
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
